apb_mem_responder: RTL and testbench
====================================

// Module: apb_mem_responder
// PURPOSE
//  APB4 completer (slave) backed by a NUM_WORDS x DATA_WIDTH register array with byte strobes,
//  programmable wait states and PSLVERR on bad addresses. It is the responder for the apb_if
//  initiator tasks and serves as the bus-side test target and scratch memory for UART benches.
// PARAMETERS
//  ADDR_WIDTH   32  paddr width
//  DATA_WIDTH   32  pwdata/prdata width; multiple of 8; BL = DATA_WIDTH/8 byte lanes
//  NUM_WORDS    16  array depth (>=1)
//  WAIT_STATES   0  cycles pready held low in access phase (0..255)
//  BASE_ADDR     0  byte address of word 0; must be BL-aligned
// PORTS
//  clk_i      in   1           clock, rising edge
//  srst_i     in   1           synchronous reset, active high
//  psel_i     in   1           peripheral select
//  penable_i  in   1           access phase
//  paddr_i    in   ADDR_WIDTH  byte address
//  pwrite_i   in   1           1 = write, 0 = read
//  pwdata_i   in   DATA_WIDTH  write data
//  pstrb_i    in   BL          write byte strobes
//  pready_o   out  1           transfer complete this cycle
//  prdata_o   out  DATA_WIDTH  read data, valid while pready_o=1 and pwrite_i=0
//  pslverr_o  out  1           error, valid while pready_o=1
// BEHAVIOUR
//  Reset (srst_i=1 at posedge): state=IDLE, cnt=0, all array words=0, pready_o=0,
//   pslverr_o=0, prdata_o=0. Reset wins over every other event, including mid-transfer
//   (transfer dropped, no write).
//  FSM states: IDLE, ACCESS. pready_o and pslverr_o decode from registers only.
//  IDLE: if psel_i & ~penable_i -> ACCESS. Capture addr, pwrite, pwdata, pstrb and err.
//   Set cnt=WAIT_STATES. Load prdata_o = err|write ? 0 : mem[idx].
//   psel_i&penable_i with no setup seen is ignored (stay IDLE).
//  Decode: off = paddr_i-BASE_ADDR; idx = off>>log2(BL).
//   err = (paddr_i<BASE_ADDR) | (idx>=NUM_WORDS) | (paddr_i[log2(BL)-1:0]!=0).
//  ACCESS: pready_o = (cnt==0); pslverr_o = pready_o & err_q.
//   cnt!=0 -> cnt-1 each cycle.
//   cnt==0 & psel_i & penable_i -> completion edge: on a write with ~err_q, each byte lane b
//   with pstrb_q[b]=1 updates mem[idx_q][8b+:8]. Then -> IDLE; prdata_o cleared to 0.
//   psel_i=0 while in ACCESS (master abort) -> IDLE, no write, no error.
//  Latency: setup + (WAIT_STATES+1) access cycles = WAIT_STATES+2 clocks per transfer.
//  Back-to-back: a new setup presented in the cycle after completion is accepted normally.
//   No idle cycle is required. The next setup is sampled one edge after completion.
//  Address/data/strobe changes during ACCESS are ignored; values captured at setup are used.
//  Write with pstrb=0: completes, no array change, pslverr_o=0. pstrb is ignored on reads.
//  Read of a word after a write returns the post-write value (write commits before next setup).
//  Error transfers: no array change; prdata_o=0.
// TESTING
//  1 reset, WAIT_STATES=0: write32 0x04<=0xDEADBEEF, read32 0x04
//    -> 0xDEADBEEF; pready_o=1 in 2nd cycle of each transfer; pslverr_o=0.
//  2 byte strobe: write 0x08<=0x11223344 strb 0xF, then 0xAABBCCDD strb 0x5
//    -> read 0x08 = 0x11BB33DD.
//  3 WAIT_STATES=3: any read -> pready_o low 3 access cycles, high on 4th; transfer=5 clocks.
//  4 errors: read 0x40 (NUM_WORDS=16), write 0x02 <= 0xFFFFFFFF
//    -> pslverr_o=1 with pready_o; prdata_o=0; word 0 unchanged.
//  5 abort/reset: WAIT_STATES=2, drop psel_i in 2nd access cycle
//    -> IDLE, target unchanged. Assert srst_i mid-access
//    -> outputs 0 next cycle, all words read 0.
//  6 back-to-back: 8 consecutive writes to 0x00..0x1C then readback
//    -> each word = written value, no lost or duplicated transfers.

Source files
------------

// File: rtl/apb_mem_responder.sv
// apb_mem_responder
//   APB4 completer backed by a NUM_WORDS x DATA_WIDTH register array. It supports byte strobes,
//   a fixed number of wait states and PSLVERR on out-of-range or misaligned addresses.
//
// Ports
//   clk_i      clock, rising edge
//   srst_i     synchronous reset, active high
//   psel_i     peripheral select
//   penable_i  access phase
//   paddr_i    byte address
//   pwrite_i   1 = write, 0 = read
//   pwdata_i   write data
//   pstrb_i    write byte strobes, one per byte lane
//   pready_o   transfer completes this cycle
//   prdata_o   read data, valid while pready_o=1 on a read
//   pslverr_o  error response, valid while pready_o=1
module apb_mem_responder #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned NUM_WORDS   = 16,
    parameter int unsigned WAIT_STATES = 0,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic                    clk_i,
    input  logic                    srst_i,
    input  logic                    psel_i,
    input  logic                    penable_i,
    input  logic [ADDR_WIDTH-1:0]   paddr_i,
    input  logic                    pwrite_i,
    input  logic [DATA_WIDTH-1:0]   pwdata_i,
    input  logic [DATA_WIDTH/8-1:0] pstrb_i,
    output logic                    pready_o,
    output logic [DATA_WIDTH-1:0]   prdata_o,
    output logic                    pslverr_o
);

    localparam int unsigned BL     = DATA_WIDTH / 8;
    localparam int unsigned LOG_BL = $clog2(BL);
    localparam int unsigned IDX_W  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK  = ADDR_WIDTH'(BL - 1);
    localparam logic [ADDR_WIDTH-1:0] NUM_WORDS_A = ADDR_WIDTH'(NUM_WORDS);

    localparam logic [0:0] StIdle   = 1'b0;
    localparam logic [0:0] StAccess = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  write_q, write_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [BL-1:0]         strb_q, strb_d;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_d;

    logic [DATA_WIDTH-1:0] mem_q [NUM_WORDS];

    logic [ADDR_WIDTH-1:0] dec_off;
    logic [ADDR_WIDTH-1:0] dec_idx_full;
    logic [IDX_W-1:0]      dec_idx;
    logic                  dec_err;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  complete;
    logic                  wr_en;

    // Address decode for the setup phase.
    always_comb begin
        dec_off      = paddr_i - BASE_ADDR;
        dec_idx_full = dec_off >> LOG_BL;
        dec_idx      = dec_idx_full[IDX_W-1:0];
        dec_err      = (paddr_i < BASE_ADDR) || (dec_idx_full >= NUM_WORDS_A) ||
                       ((paddr_i & ALIGN_MASK) != '0);
        rd_word      = '0;
        // Only index the array for in-range addresses; errored reads return zero anyway.
        if (!dec_err) begin
            rd_word = mem_q[dec_idx];
        end
    end

    assign complete = (state_q == StAccess) && (cnt_q == 8'd0) && psel_i && penable_i;
    assign wr_en    = complete && write_q && !err_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        write_d  = write_q;
        err_d    = err_q;
        wdata_d  = wdata_q;
        strb_d   = strb_q;
        prdata_d = prdata_q;
        case (state_q)
            StIdle: begin
                // Access-phase signals without a preceding setup are ignored.
                if (psel_i && !penable_i) begin
                    state_d  = StAccess;
                    cnt_d    = 8'(WAIT_STATES);
                    idx_d    = dec_idx;
                    write_d  = pwrite_i;
                    err_d    = dec_err;
                    wdata_d  = pwdata_i;
                    strb_d   = pstrb_i;
                    prdata_d = (dec_err || pwrite_i) ? '0 : rd_word;
                end
            end
            StAccess: begin
                if (!psel_i) begin
                    // Master abort: drop the transfer silently.
                    state_d  = StIdle;
                    prdata_d = '0;
                end else if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else if (penable_i) begin
                    state_d  = StIdle;
                    prdata_d = '0;
                end
            end
            default: begin
                state_d  = StIdle;
                prdata_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q  <= StIdle;
            cnt_q    <= 8'd0;
            idx_q    <= '0;
            write_q  <= 1'b0;
            err_q    <= 1'b0;
            wdata_q  <= '0;
            strb_q   <= '0;
            prdata_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            write_q  <= write_d;
            err_q    <= err_d;
            wdata_q  <= wdata_d;
            strb_q   <= strb_d;
            prdata_q <= prdata_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            for (int unsigned i = 0; i < NUM_WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            for (int unsigned b = 0; b < BL; b++) begin
                if (strb_q[b]) begin
                    mem_q[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

    // Handshake outputs come straight from registers.
    assign pready_o  = (state_q == StAccess) && (cnt_q == 8'd0);
    assign pslverr_o = pready_o && err_q;
    assign prdata_o  = prdata_q;

endmodule

// File: tb/tb_apb_mem_responder.sv
// tb_apb_mem_responder
//   Bench for apb_mem_responder. Three instances share one APB bus (selected by sel) with
//   WAIT_STATES = 0, 3 and 2. A vector table exercises the zero-wait instance; hand-written
//   sequences cover wait states, master abort, reset mid-access and back-to-back transfers.
module tb_apb_mem_responder;

    logic        clk = 1'b0;
    logic        srst;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic [3:0]  pstrb;
    int          sel;
    int          cyc = 0;

    logic        psel0, psel3, psel2;
    logic        pready0, pready3, pready2;
    logic        pslverr0, pslverr3, pslverr2;
    logic [31:0] prdata0, prdata3, prdata2;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign psel0 = psel && (sel == 0);
    assign psel3 = psel && (sel == 3);
    assign psel2 = psel && (sel == 2);

    apb_mem_responder #(.WAIT_STATES(0)) u_ws0 (
        .clk_i(clk), .srst_i(srst), .psel_i(psel0), .penable_i(penable), .paddr_i(paddr),
        .pwrite_i(pwrite), .pwdata_i(pwdata), .pstrb_i(pstrb), .pready_o(pready0),
        .prdata_o(prdata0), .pslverr_o(pslverr0)
    );
    apb_mem_responder #(.WAIT_STATES(3)) u_ws3 (
        .clk_i(clk), .srst_i(srst), .psel_i(psel3), .penable_i(penable), .paddr_i(paddr),
        .pwrite_i(pwrite), .pwdata_i(pwdata), .pstrb_i(pstrb), .pready_o(pready3),
        .prdata_o(prdata3), .pslverr_o(pslverr3)
    );
    apb_mem_responder #(.WAIT_STATES(2)) u_ws2 (
        .clk_i(clk), .srst_i(srst), .psel_i(psel2), .penable_i(penable), .paddr_i(paddr),
        .pwrite_i(pwrite), .pwdata_i(pwdata), .pstrb_i(pstrb), .pready_o(pready2),
        .prdata_o(prdata2), .pslverr_o(pslverr2)
    );

    function automatic logic cur_pready();
        return (sel == 0) ? pready0 : (sel == 3) ? pready3 : pready2;
    endfunction
    function automatic logic cur_pslverr();
        return (sel == 0) ? pslverr0 : (sel == 3) ? pslverr3 : pslverr2;
    endfunction
    function automatic logic [31:0] cur_prdata();
        return (sel == 0) ? prdata0 : (sel == 3) ? prdata3 : prdata2;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Called just after a rising edge; returns just after the completion edge.
    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] s, output logic [31:0] rd, output logic err,
                        output int waits);
        psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = wd; pstrb = s;
        @(posedge clk); #1;
        penable = 1'b1;
        waits = 0;
        while (!cur_pready() && waits < 300) begin
            @(posedge clk); #1;
            waits++;
        end
        rd  = cur_prdata();
        err = cur_pslverr();
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] wd;
        logic [3:0]  s;
        logic [31:0] erd;
        logic        eerr;
    } vec_t;

    vec_t vt[16];

    initial begin
        logic [31:0] rd;
        logic        err;
        int          waits;
        int          c0;

        vt[0]  = '{1'b1, 32'h04, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
        vt[1]  = '{1'b0, 32'h04, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
        vt[2]  = '{1'b1, 32'h08, 32'h11223344, 4'hF, 32'h0,        1'b0};
        vt[3]  = '{1'b1, 32'h08, 32'hAABBCCDD, 4'h5, 32'h0,        1'b0};
        vt[4]  = '{1'b0, 32'h08, 32'h0,        4'h0, 32'h11BB33DD, 1'b0};
        vt[5]  = '{1'b1, 32'h00, 32'hCAFEF00D, 4'hF, 32'h0,        1'b0};
        vt[6]  = '{1'b0, 32'h40, 32'h0,        4'h0, 32'h0,        1'b1};
        vt[7]  = '{1'b1, 32'h02, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1};
        vt[8]  = '{1'b0, 32'h00, 32'h0,        4'hF, 32'hCAFEF00D, 1'b0};
        vt[9]  = '{1'b1, 32'h00, 32'h55555555, 4'h0, 32'h0,        1'b0};
        vt[10] = '{1'b0, 32'h00, 32'h0,        4'h0, 32'hCAFEF00D, 1'b0};
        vt[11] = '{1'b0, 32'h3C, 32'h0,        4'h0, 32'h0,        1'b0};
        vt[12] = '{1'b0, 32'h3D, 32'h0,        4'h0, 32'h0,        1'b1};
        vt[13] = '{1'b1, 32'h3C, 32'h01020304, 4'hF, 32'h0,        1'b0};
        vt[14] = '{1'b0, 32'h3C, 32'h0,        4'h0, 32'h01020304, 1'b0};
        vt[15] = '{1'b0, 32'h04, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0};

        srst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0; sel = 0;
        repeat (3) @(posedge clk);
        #1 srst = 1'b0;

        check("rst_pready0",  {31'b0, pready0},  32'h0);
        check("rst_pslverr0", {31'b0, pslverr0}, 32'h0);
        check("rst_prdata0",  prdata0,           32'h0);
        check("rst_pready3",  {31'b0, pready3},  32'h0);
        check("rst_prdata2",  prdata2,           32'h0);

        // Zero-wait vector table.
        sel = 0;
        for (int i = 0; i < 16; i++) begin
            xfer(vt[i].w, vt[i].a, vt[i].wd, vt[i].s, rd, err, waits);
            check($sformatf("vec%0d_waits", i), waits, 32'd0);
            check($sformatf("vec%0d_err", i), {31'b0, err}, {31'b0, vt[i].eerr});
            check($sformatf("vec%0d_rdata", i), rd, vt[i].erd);
            @(posedge clk); #1;
        end

        // Three wait states: pready low for 3 access cycles, transfer spans 5 clocks.
        sel = 3;
        c0 = cyc;
        xfer(1'b1, 32'h10, 32'h0BADF00D, 4'hF, rd, err, waits);
        check("ws3_write_waits", waits, 32'd3);
        check("ws3_write_clocks", cyc - c0, 32'd5);
        xfer(1'b0, 32'h10, 32'h0, 4'h0, rd, err, waits);
        check("ws3_read_waits", waits, 32'd3);
        check("ws3_read_data", rd, 32'h0BADF00D);
        check("ws3_read_err", {31'b0, err}, 32'h0);

        // Two wait states with master abort in the second access cycle.
        sel = 2;
        @(posedge clk); #1;
        xfer(1'b1, 32'h0C, 32'h12345678, 4'hF, rd, err, waits);
        check("ws2_write_waits", waits, 32'd2);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0C;
        pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
        @(posedge clk); #1;
        penable = 1'b1;
        check("abort_acc1_pready", {31'b0, pready2}, 32'h0);
        @(posedge clk); #1;
        check("abort_acc2_pready", {31'b0, pready2}, 32'h0);
        psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        check("abort_idle_pready", {31'b0, pready2}, 32'h0);
        check("abort_idle_pslverr", {31'b0, pslverr2}, 32'h0);
        @(posedge clk); #1;
        check("abort_stays_idle", {31'b0, pready2}, 32'h0);
        xfer(1'b0, 32'h0C, 32'h0, 4'h0, rd, err, waits);
        check("abort_target_kept", rd, 32'h12345678);
        check("abort_read_waits", waits, 32'd2);

        // Reset in the middle of a read access.
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h0C;
        @(posedge clk); #1;
        penable = 1'b1;
        check("mid_read_prdata", prdata2, 32'h12345678);
        check("mid_read_pready", {31'b0, pready2}, 32'h0);
        srst = 1'b1; psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        check("srst_pready", {31'b0, pready2}, 32'h0);
        check("srst_pslverr", {31'b0, pslverr2}, 32'h0);
        check("srst_prdata", prdata2, 32'h0);
        srst = 1'b0;
        xfer(1'b0, 32'h0C, 32'h0, 4'h0, rd, err, waits);
        check("srst_word3_zero", rd, 32'h0);
        xfer(1'b0, 32'h04, 32'h0, 4'h0, rd, err, waits);
        check("srst_ws0_word_zero_via_ws2", rd, 32'h0);
        sel = 0;
        xfer(1'b0, 32'h04, 32'h0, 4'h0, rd, err, waits);
        check("srst_ws0_word1_zero", rd, 32'h0);

        // Back-to-back writes then reads, no idle cycles in between.
        c0 = cyc;
        for (int i = 0; i < 8; i++) begin
            xfer(1'b1, 32'(i * 4), 32'h01010101 * 32'(i + 1) ^ 32'hA5000000, 4'hF,
                 rd, err, waits);
        end
        check("b2b_write_clocks", cyc - c0, 32'd16);
        c0 = cyc;
        for (int i = 0; i < 8; i++) begin
            xfer(1'b0, 32'(i * 4), 32'h0, 4'h0, rd, err, waits);
            check($sformatf("b2b_read%0d", i), rd, 32'h01010101 * 32'(i + 1) ^ 32'hA5000000);
        end
        check("b2b_read_clocks", cyc - c0, 32'd16);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
